urv_dm_arbiter: RTL
===================

Name: urv_dm_arbiter

Overview:
- Shares one data-memory slave port between two masters: the execute stage's load/store port (core, C) and the debug/DMA port (D).
- Sits between the execute/writeback stages, the debug module and the data memory.
- The request path is combinational so the core sees no added latency.
- Tracks the single outstanding load so that read data returns to its owner.
- A timeout completes loads that get no response.

Parameters:
- g_fixed_priority, 0, 1 = C always wins over D; 0 = round-robin on contention.
- g_rdata_timeout, 255, max cycles to wait for m_rvalid_i after a load is accepted; 0 disables the timeout; legal range 0..65535.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- c_addr_i  in  32  core address
- c_data_s_i  in  32  core store data
- c_select_i  in  4  core byte select
- c_load_i  in  1  core load request
- c_store_i  in  1  core store request
- c_ready_o  out  1  core request accepted this cycle (feeds dm_ready_i)
- c_data_l_o  out  32  load data to the core
- c_load_done_o  out  1  core load data valid (1-cycle pulse)
- d_addr_i  in  32  debug address
- d_data_s_i  in  32  debug store data
- d_select_i  in  4  debug byte select
- d_load_i  in  1  debug load request
- d_store_i  in  1  debug store request
- d_ready_o  out  1  debug request accepted
- d_data_l_o  out  32  load data to debug
- d_load_done_o  out  1  debug load data valid
- m_addr_o  out  32  slave address
- m_data_s_o  out  32  slave store data
- m_select_o  out  4  slave byte select
- m_load_o  out  1  slave load strobe
- m_store_o  out  1  slave store strobe
- m_ready_i  in  1  slave accepts the strobe this cycle
- m_data_l_i  in  32  slave read data
- m_rvalid_i  in  1  slave read data valid
- timeout_o  out  1  1-cycle pulse when a load times out

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high.
- Request definitions: req_C = c_load_i|c_store_i; req_D = d_load_i|d_store_i. Load and store asserted together on one master is illegal; treat it as a load.
- Masters:
  - D holds its request and its fields stable until d_ready_o.
  - C may withdraw an unaccepted request (pipeline kill). No state changes for a withdrawn request.
- States:
  - IDLE: no outstanding load.
  - WAIT_C: C load outstanding.
  - WAIT_D: D load outstanding.
- Grant window open: state == IDLE, or m_rvalid_i == 1 in WAIT_C/WAIT_D (back-to-back load allowed in the response cycle).
- Winner, when the window is open:
  - Only one master requesting: that master wins.
  - Both requesting, g_fixed_priority = 1: C wins.
  - Both requesting, otherwise: the master not equal to last_grant wins.
  - last_grant resets to D, so C wins the first contention.
- Slave side, combinational:
  - m_addr/m_data_s/m_select are muxed from the winner.
  - m_load_o/m_store_o = winner's strobe while the window is open, else 0.
  - With no winner, fields are don't-care and strobes are 0.
- Ready:
  - c_ready_o = window open & C wins & m_ready_i; d_ready_o likewise.
  - c_ready_o is also 1 whenever req_C == 0, so the core never stalls without a request.
- Acceptance (strobe & m_ready_i):
  - last_grant <= winner.
  - A load moves to WAIT_<winner>, with the timeout counter cleared.
  - A store moves to IDLE; if it is accepted in an rvalid cycle, the state still goes to IDLE.
- Response, in the m_rvalid_i cycle while in WAIT_x:
  - x_data_l_o = m_data_l_i; x_load_done_o = 1 for exactly one cycle.
  - The state moves to IDLE unless a new load is accepted in the same cycle.
  - m_rvalid_i in IDLE is ignored: no done pulse, no state change.
- Timeout (g_rdata_timeout != 0):
  - A 16-bit counter increments each cycle in WAIT_x.
  - In the cycle the counter == g_rdata_timeout - 1 with no rvalid: x_load_done_o = 1, x_data_l_o = 32'hDEADBEEF, timeout_o = 1, next state IDLE.
  - The grant window stays closed in that cycle; a late rvalid arriving afterwards is ignored.
- Done outputs: c_/d_load_done_o and timeout_o are registered-free combinational pulses derived from the state. c_/d_data_l_o = m_data_l_i, or the 0xDEADBEEF override on timeout.
- Reset: state IDLE, last_grant = D, counter = 0. Consequently all strobes, done pulses and timeout_o = 0, and d_ready_o = 0 in the reset cycle.
- Reset mid-operation: any outstanding load is abandoned; its later rvalid is ignored.

Test Plan:
- C store to 0x100 with data 0xA5A5A5A5, select 4'hF, m_ready_i = 1 -> m_store_o = 1, m_addr_o = 0x100 in the same cycle; c_ready_o = 1; state stays IDLE.
- C and D loads together, round-robin, slave rvalid 2 cycles after accept -> C granted first, then D granted in C's rvalid cycle; done pulses route to C then D with the correct data; last_grant alternates over 4 contentions.
- g_fixed_priority = 1 with C and D both requesting every cycle for 6 grants -> D never granted; C granted each time.
- D load accepted, slave never asserts rvalid, g_rdata_timeout = 8 -> d_load_done_o and timeout_o pulse exactly 8 cycles after accept with d_data_l_o = 0xDEADBEEF; a rvalid on cycle 10 causes no done pulse.
- C load with m_ready_i = 0 for 3 cycles, C withdraws on cycle 2 -> c_ready_o = 0 while requesting, no slave acceptance, state stays IDLE, last_grant unchanged.
- rst_i asserted while in WAIT_C, then rvalid one cycle later -> all outputs 0, no c_load_done_o, next request granted normally.

Source files
------------

// File: rtl/urv_dm_arbiter.sv
// urv_dm_arbiter: shares one data-memory slave port between the core (C) and debug/DMA (D) masters
module urv_dm_arbiter #(
  parameter int g_fixed_priority = 0,
  parameter int g_rdata_timeout  = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] c_addr_i,
  input  logic [31:0] c_data_s_i,
  input  logic [3:0]  c_select_i,
  input  logic        c_load_i,
  input  logic        c_store_i,
  output logic        c_ready_o,
  output logic [31:0] c_data_l_o,
  output logic        c_load_done_o,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_s_i,
  input  logic [3:0]  d_select_i,
  input  logic        d_load_i,
  input  logic        d_store_i,
  output logic        d_ready_o,
  output logic [31:0] d_data_l_o,
  output logic        d_load_done_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_s_o,
  output logic [3:0]  m_select_o,
  output logic        m_load_o,
  output logic        m_store_o,
  input  logic        m_ready_i,
  input  logic [31:0] m_data_l_i,
  input  logic        m_rvalid_i,
  output logic        timeout_o
);
  typedef enum logic [1:0] {IDLE, WAIT_C, WAIT_D} state_t;
  localparam logic [15:0] TMO_LAST = 16'(g_rdata_timeout - 1);
  state_t state;
  logic last_d;
  logic [15:0] cnt;
  logic req_c, req_d, busy, timed, window, win_c, win_d, accept, resp;
  assign req_c = c_load_i | c_store_i;
  assign req_d = d_load_i | d_store_i;
  assign busy = state != IDLE;
  assign timed = (g_rdata_timeout != 0) & busy & !m_rvalid_i & (cnt == TMO_LAST);
  assign window = !rst_i & (!busy | m_rvalid_i);
  assign win_c = window & req_c & (!req_d | (g_fixed_priority != 0) | last_d);
  assign win_d = window & req_d & !win_c;
  assign m_addr_o = win_d ? d_addr_i : c_addr_i;
  assign m_data_s_o = win_d ? d_data_s_i : c_data_s_i;
  assign m_select_o = win_d ? d_select_i : c_select_i;
  assign m_load_o = win_c ? c_load_i : win_d & d_load_i;
  assign m_store_o = win_c ? c_store_i & !c_load_i : win_d & d_store_i & !d_load_i;
  assign accept = (m_load_o | m_store_o) & m_ready_i;
  assign c_ready_o = !req_c | (win_c & m_ready_i);
  assign d_ready_o = win_d & m_ready_i;
  assign resp = !rst_i & busy & (m_rvalid_i | timed);
  assign c_load_done_o = resp & (state == WAIT_C);
  assign d_load_done_o = resp & (state == WAIT_D);
  assign timeout_o = !rst_i & timed;
  assign c_data_l_o = timed ? 32'hDEADBEEF : m_data_l_i;
  assign d_data_l_o = timed ? 32'hDEADBEEF : m_data_l_i;
  // outstanding-load owner, round-robin history and response timeout counter
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      last_d <= 1'b1;
      cnt <= '0;
    end else if (accept) begin
      last_d <= win_d;
      state <= !m_load_o ? IDLE : win_d ? WAIT_D : WAIT_C;
      cnt <= '0;
    end else if (resp)
      state <= IDLE;
    else if (busy)
      cnt <= cnt + 16'd1;
endmodule
